// File: rtl/sync_mode_pkg.sv
// Shared types, video timing table and state encoding for the sync-mode sequencer.
// Horizontal and vertical entries are stored 12 bits wide; the top resizes them to X_BITS/Y_BITS.
package sync_mode_pkg;

  localparam int NUM_MODES_MAX = 4;
  localparam int IDX_W         = $clog2(NUM_MODES_MAX);
  localparam int PW            = 12;

  typedef enum logic [1:0] {
    ST_HOLD       = 2'd0,
    ST_RUN        = 2'd1,
    ST_WAIT_FRAME = 2'd2,
    ST_LOAD       = 2'd3
  } state_t;

  typedef struct packed {
    logic          interlaced;
    logic [PW-1:0] h_total;
    logic [PW-1:0] h_fp;
    logic [PW-1:0] h_bp;
    logic [PW-1:0] h_sync;
    logic [PW-1:0] hv_offset_0;
    logic [PW-1:0] hv_offset_1;
    logic [PW-1:0] v_total_0;
    logic [PW-1:0] v_total_1;
    logic [PW-1:0] v_fp_0;
    logic [PW-1:0] v_fp_1;
    logic [PW-1:0] v_bp_0;
    logic [PW-1:0] v_bp_1;
    logic [PW-1:0] v_sync_0;
    logic [PW-1:0] v_sync_1;
  } mode_t;

  // Progressive modes repeat field 0 timing in the field 1 slots.
  localparam mode_t MODE_640X480P = '{
    interlaced: 1'b0,
    h_total: 12'd800, h_fp: 12'd16, h_bp: 12'd48, h_sync: 12'd96,
    hv_offset_0: 12'd0, hv_offset_1: 12'd0,
    v_total_0: 12'd525, v_total_1: 12'd525,
    v_fp_0: 12'd10, v_fp_1: 12'd10,
    v_bp_0: 12'd33, v_bp_1: 12'd33,
    v_sync_0: 12'd2, v_sync_1: 12'd2
  };

  localparam mode_t MODE_720P = '{
    interlaced: 1'b0,
    h_total: 12'd1650, h_fp: 12'd110, h_bp: 12'd220, h_sync: 12'd40,
    hv_offset_0: 12'd0, hv_offset_1: 12'd0,
    v_total_0: 12'd750, v_total_1: 12'd750,
    v_fp_0: 12'd5, v_fp_1: 12'd5,
    v_bp_0: 12'd20, v_bp_1: 12'd20,
    v_sync_0: 12'd5, v_sync_1: 12'd5
  };

  localparam mode_t MODE_1080P = '{
    interlaced: 1'b0,
    h_total: 12'd2200, h_fp: 12'd88, h_bp: 12'd148, h_sync: 12'd44,
    hv_offset_0: 12'd0, hv_offset_1: 12'd0,
    v_total_0: 12'd1125, v_total_1: 12'd1125,
    v_fp_0: 12'd4, v_fp_1: 12'd4,
    v_bp_0: 12'd36, v_bp_1: 12'd36,
    v_sync_0: 12'd5, v_sync_1: 12'd5
  };

  localparam mode_t MODE_1080I = '{
    interlaced: 1'b1,
    h_total: 12'd2200, h_fp: 12'd88, h_bp: 12'd148, h_sync: 12'd44,
    hv_offset_0: 12'd0, hv_offset_1: 12'd1100,
    v_total_0: 12'd562, v_total_1: 12'd563,
    v_fp_0: 12'd2, v_fp_1: 12'd2,
    v_bp_0: 12'd15, v_bp_1: 12'd16,
    v_sync_0: 12'd5, v_sync_1: 12'd5
  };

endpackage

// File: rtl/sync_mode_rom.sv
// Combinational lookup of a video timing record by mode index.
module sync_mode_rom
  import sync_mode_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output mode_t            mode
);

  // Table decode; unknown indices fall back to the boot mode.
  always_comb begin
    mode = MODE_640X480P;
    case (idx)
      2'd0:    mode = MODE_640X480P;
      2'd1:    mode = MODE_720P;
      2'd2:    mode = MODE_1080P;
      2'd3:    mode = MODE_1080I;
      default: mode = MODE_640X480P;
    endcase
  end

endmodule

// File: rtl/sync_mode_ctrl.sv
// Mode sequencer for the HDMI sync generator: accepts mode requests and applies them at a
// frame boundary by holding the generator in reset while its timing parameters are reloaded.
module sync_mode_ctrl
  import sync_mode_pkg::*;
#(
  parameter int X_BITS        = 12,
  parameter int Y_BITS        = 12,
  parameter int NUM_MODES     = 4,
  parameter int HOLD_CYCLES   = 16,
  parameter int FRAME_TIMEOUT = 4194304,
  localparam int MW           = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode_req_valid,
  input  logic [MW-1:0]     mode_req_id,
  output logic              mode_req_ready,
  input  logic              vs_in,
  input  logic              field_in,
  output logic              sg_reset,
  output logic              interlaced,
  output logic [X_BITS-1:0] h_total,
  output logic [X_BITS-1:0] h_fp,
  output logic [X_BITS-1:0] h_bp,
  output logic [X_BITS-1:0] h_sync,
  output logic [X_BITS-1:0] hv_offset_0,
  output logic [X_BITS-1:0] hv_offset_1,
  output logic [Y_BITS-1:0] v_total_0,
  output logic [Y_BITS-1:0] v_total_1,
  output logic [Y_BITS-1:0] v_fp_0,
  output logic [Y_BITS-1:0] v_fp_1,
  output logic [Y_BITS-1:0] v_bp_0,
  output logic [Y_BITS-1:0] v_bp_1,
  output logic [Y_BITS-1:0] v_sync_0,
  output logic [Y_BITS-1:0] v_sync_1,
  output logic [MW-1:0]     mode_cur,
  output logic              busy,
  output logic              switch_done,
  output logic              err_bad_mode,
  output logic              err_timeout
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TW = 23;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(FRAME_TIMEOUT - 1);

  state_t           state_r;
  logic [HW-1:0]    hold_cnt_r;
  logic [TW-1:0]    tmo_cnt_r;
  logic [MW-1:0]    req_id_r;
  logic             vs_q_r;
  mode_t            params_r;
  mode_t            rom_mode_s;
  logic [IDX_W-1:0] rom_idx_s;
  logic             frame_edge_s;
  logic             accept_s;
  logic             bad_id_s;

  assign rom_idx_s = IDX_W'(req_id_r);

  sync_mode_rom u_rom (
    .idx  (rom_idx_s),
    .mode (rom_mode_s)
  );

  // Only a field-0 rising vsync marks a frame start; field-1 edges of interlaced modes are skipped.
  assign frame_edge_s = vs_in & ~vs_q_r & ~field_in;
  assign accept_s     = mode_req_valid & mode_req_ready;
  assign bad_id_s     = ({1'b0, mode_req_id} >= (MW + 1)'(NUM_MODES));

  assign interlaced  = params_r.interlaced;
  assign h_total     = X_BITS'(params_r.h_total);
  assign h_fp        = X_BITS'(params_r.h_fp);
  assign h_bp        = X_BITS'(params_r.h_bp);
  assign h_sync      = X_BITS'(params_r.h_sync);
  assign hv_offset_0 = X_BITS'(params_r.hv_offset_0);
  assign hv_offset_1 = X_BITS'(params_r.hv_offset_1);
  assign v_total_0   = Y_BITS'(params_r.v_total_0);
  assign v_total_1   = Y_BITS'(params_r.v_total_1);
  assign v_fp_0      = Y_BITS'(params_r.v_fp_0);
  assign v_fp_1      = Y_BITS'(params_r.v_fp_1);
  assign v_bp_0      = Y_BITS'(params_r.v_bp_0);
  assign v_bp_1      = Y_BITS'(params_r.v_bp_1);
  assign v_sync_0    = Y_BITS'(params_r.v_sync_0);
  assign v_sync_1    = Y_BITS'(params_r.v_sync_1);

  // Sequencer FSM with registered handshake, generator reset, status and parameter outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_HOLD;
      hold_cnt_r     <= '0;
      tmo_cnt_r      <= '0;
      req_id_r       <= '0;
      vs_q_r         <= 1'b0;
      params_r       <= MODE_640X480P;
      mode_cur       <= '0;
      sg_reset       <= 1'b1;
      mode_req_ready <= 1'b0;
      busy           <= 1'b1;
      switch_done    <= 1'b0;
      err_bad_mode   <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      vs_q_r       <= vs_in;
      switch_done  <= 1'b0;
      err_bad_mode <= 1'b0;
      err_timeout  <= 1'b0;
      case (state_r)
        ST_HOLD: begin
          if (hold_cnt_r == HOLD_LAST) begin
            state_r        <= ST_RUN;
            hold_cnt_r     <= '0;
            sg_reset       <= 1'b0;
            switch_done    <= 1'b1;
            mode_req_ready <= 1'b1;
            busy           <= 1'b0;
          end else begin
            hold_cnt_r <= hold_cnt_r + HW'(1);
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            if (bad_id_s) begin
              err_bad_mode <= 1'b1;
            end else if (mode_req_id == mode_cur) begin
              switch_done <= 1'b1;
            end else begin
              req_id_r       <= mode_req_id;
              tmo_cnt_r      <= '0;
              state_r        <= ST_WAIT_FRAME;
              mode_req_ready <= 1'b0;
              busy           <= 1'b1;
            end
          end
        end
        ST_WAIT_FRAME: begin
          // A boundary coinciding with the timeout wins, so no error is flagged then.
          if (frame_edge_s || (tmo_cnt_r == TMO_LAST)) begin
            state_r     <= ST_LOAD;
            sg_reset    <= 1'b1;
            params_r    <= rom_mode_s;
            mode_cur    <= req_id_r;
            err_timeout <= ~frame_edge_s;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
        end
        ST_LOAD: begin
          state_r    <= ST_HOLD;
          hold_cnt_r <= '0;
        end
        default: begin
          state_r        <= ST_HOLD;
          hold_cnt_r     <= '0;
          sg_reset       <= 1'b1;
          mode_req_ready <= 1'b0;
          busy           <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/sync_mode_ctrl.md
# sync_mode_ctrl

Mode sequencer for the HDMI sync generator. It holds a table of supported video timings and drives the generator's timing-parameter inputs and its active-high reset. It accepts mode-change requests over a valid/ready handshake and applies each change only at a frame boundary: generator held in reset, new parameters loaded, generator released. It sits between the system control path and the sync generator in the HDMI controller.

## Interface
- X_BITS, 12, horizontal parameter width
- Y_BITS, 12, vertical parameter width
- NUM_MODES, 4, table entries; ID width MW = $clog2(NUM_MODES)
- HOLD_CYCLES, 16, cycles the generator reset is held after a load
- FRAME_TIMEOUT, 4194304, max cycles waiting for a frame boundary

Ports:
- clk  in  1  pixel clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- mode_req_valid  in  1  request present
- mode_req_id  in  MW  requested mode index
- mode_req_ready  out  1  request accepted when valid&ready
- vs_in  in  1  generator vs_out
- field_in  in  1  generator field_out
- sg_reset  out  1  active-high reset to the generator
- interlaced  out  1  to generator
- h_total, h_fp, h_bp, h_sync, hv_offset_0, hv_offset_1  out  X_BITS  to generator
- v_total_0/1, v_fp_0/1, v_bp_0/1, v_sync_0/1  out  Y_BITS  to generator
- mode_cur  out  MW  mode currently applied
- busy  out  1  switch in progress (state != RUN)
- switch_done  out  1  one-cycle pulse: new mode running
- err_bad_mode  out  1  one-cycle pulse: request ID ≥ NUM_MODES
- err_timeout  out  1  one-cycle pulse: boundary wait timed out

## Operation
- States: HOLD, RUN, WAIT_FRAME, LOAD.
- Reset (async, reset=0):
  - state=HOLD, hold counter=0.
  - sg_reset=1; all parameter outputs and interlaced = mode 0; mode_cur=0.
  - mode_req_ready=0, busy=1; all pulse outputs 0.
- HOLD: count HOLD_CYCLES cycles, then go to RUN. On entering RUN: sg_reset=0, switch_done=1 for one cycle. This covers both boot and every switch.
- RUN: mode_req_ready=1. On accept:
  - ID ≥ NUM_MODES: err_bad_mode pulse next cycle; stay in RUN.
  - ID == mode_cur: switch_done pulse next cycle; no reset; stay in RUN.
  - Otherwise: latch the ID and go to WAIT_FRAME.
- WAIT_FRAME: the frame boundary is a rising edge of vs_in (one-flop edge detector) while field_in=0.
  - On boundary: go to LOAD.
  - When the timeout counter reaches FRAME_TIMEOUT-1: go to LOAD and pulse err_timeout.
- LOAD (one cycle): sg_reset=1; all parameter outputs and mode_cur updated from the table entry; go to HOLD.
- Parameters change only in LOAD or reset, so they are stable whenever sg_reset=0.
- mode_req_ready=0 in all states except RUN. Requests are never queued.
- Reset asserted in any state aborts the switch and returns to the reset state; the latched request is discarded.

## Timing
- All outputs are registered.
- Accept at edge T: busy=1 and ready=0 from T+1.
- vs_in rising is first sampled high at edge E: LOAD at E+1, which makes sg_reset=1 and new parameters visible at E+1.
- sg_reset stays high for exactly 1+HOLD_CYCLES cycles. It falls in the same cycle switch_done pulses and ready rises.
- After reset release: first switch_done at cycle HOLD_CYCLES.
- Timeout counter: 23 bits, cleared on entry to WAIT_FRAME. A boundary and a timeout in the same cycle count as a boundary (no err_timeout).
- A vs_in rising edge while field_in=1 is ignored, so interlaced modes switch only at the start of field 0.

## Structure
- Package sync_mode_pkg holds:
  - the mode record type (interlaced plus every parameter);
  - the mode table constants;
  - NUM_MODES_MAX and the state encoding.
- Mode table:
  - 0 = 640x480p: 800/16/96/48, 525/10/2/33.
  - 1 = 720p: 1650/110/40/220, 750/5/5/20.
  - 2 = 1080p: 2200/88/44/148, 1125/4/5/36.
  - 3 = 1080i: same horizontal as mode 2; field 0 = 562/2/5/15, field 1 = 563/2/5/16; hv_offset_1 = 1100.
  - hv_offset_0 = 0 in all modes; progressive modes copy field 0 into field 1.
- One sub-module, sync_mode_rom: combinational index to record.

## Test plan
- Boot: reset released, no requests -> sg_reset high 16 cycles; switch_done at cycle 16; h_total=800, v_total_0=525, mode_cur=0.
- Switch 0->2: request ID 2 mid-frame -> no change until vs_in rises; next cycle h_total=2200, v_total_0=1125, sg_reset=1 for 17 cycles; then switch_done, mode_cur=2.
- Interlaced: switch to 3, then request 1 -> vs_in rise with field_in=1 ignored; LOAD follows the field_in=0 rise; interlaced goes 1->0.
- Errors: request ID 2 while mode_cur=2 -> switch_done next cycle, sg_reset stays 0. Invalid ID (NUM_MODES=3, ID 3) -> err_bad_mode pulse, outputs unchanged. vs_in tied low with FRAME_TIMEOUT=64 -> err_timeout and LOAD at cycle 64 after accept.
- Mid-switch reset: assert reset during HOLD of a 0->1 switch -> immediate mode 0 outputs and sg_reset=1; boot sequence repeats.
